// File: rtl/nanop_sequencer.sv
// Fetch/decode/execute sequencer of the nanoprocessor: owns PC, ACC, C/Z flags,
// the memory port and the OUT port; the ALU itself sits outside this block.
module nanop_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic [7:0] alu_I,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic       alu_cin,
    input  logic [7:0] alu_out,
    input  logic       alu_cout,
    output logic [7:0] acc,
    output logic       flag_c,
    output logic       flag_z,
    output logic [7:0] out_port,
    output logic       out_valid
);

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_ADC = 8'h03;
    localparam logic [7:0] OP_SBC = 8'h04;
    localparam logic [7:0] OP_ROL = 8'h05;
    localparam logic [7:0] OP_ROR = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;
    localparam logic [7:0] OP_AND = 8'h08;
    localparam logic [7:0] OP_OR  = 8'h09;
    localparam logic [7:0] OP_LDA = 8'h0A;
    localparam logic [7:0] OP_STA = 8'h0B;
    localparam logic [7:0] OP_OUT = 8'h0C;
    localparam logic [7:0] OP_JMP = 8'h0D;
    localparam logic [7:0] OP_JNC = 8'h0E;
    localparam logic [7:0] OP_JNZ = 8'h0F;

    typedef enum logic [1:0] {
        ST_IF = 2'd0,
        ST_AF = 2'd1,
        ST_EX = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] i_reg;
    logic [7:0] adr;
    logic [7:0] acc_q;
    logic       c_q;
    logic       z_q;

    // Execute addresses the operand; both fetch phases walk the PC.
    always_comb begin
        mem_addr = pc;
        if (state == ST_EX) begin
            mem_addr = adr;
        end
    end

    assign mem_wdata = acc_q;
    assign alu_I     = i_reg;
    assign alu_op1   = acc_q;
    assign alu_op2   = mem_rdata;
    assign alu_cin   = c_q;
    assign acc       = acc_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IF;
            pc        <= RESET_PC;
            i_reg     <= OP_NOP;
            adr       <= 8'h00;
            acc_q     <= 8'h00;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            out_port  <= 8'h00;
            out_valid <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                ST_IF: begin
                    if (run) begin
                        i_reg <= mem_rdata;
                        pc    <= pc + 8'd1;
                        state <= ST_AF;
                    end
                end
                ST_AF: begin
                    adr    <= mem_rdata;
                    pc     <= pc + 8'd1;
                    // Write strobe is registered so it covers exactly the EX cycle.
                    mem_we <= (i_reg == OP_STA);
                    state  <= ST_EX;
                end
                ST_EX: begin
                    state <= ST_IF;
                    case (i_reg)
                        OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_ROL, OP_ROR: begin
                            acc_q <= alu_out;
                            c_q   <= alu_cout;
                            z_q   <= (alu_out == 8'h00);
                        end
                        OP_XOR, OP_AND, OP_OR: begin
                            acc_q <= alu_out;
                            z_q   <= (alu_out == 8'h00);
                        end
                        OP_LDA: begin
                            acc_q <= mem_rdata;
                            z_q   <= (mem_rdata == 8'h00);
                        end
                        OP_OUT: begin
                            out_port  <= acc_q;
                            out_valid <= 1'b1;
                        end
                        OP_JMP: pc <= adr;
                        OP_JNC: begin
                            if (!c_q) begin
                                pc <= adr;
                            end
                        end
                        OP_JNZ: begin
                            if (!z_q) begin
                                pc <= adr;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state <= ST_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_nanop_sequencer.sv
// Bench for nanop_sequencer: instruction-level reference model with a per-cycle
// compare process, plus directed programs with hand-computed literal checks.
module tb_nanop_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       run = 1'b0;
    logic [7:0] mem_addr, mem_rdata, mem_wdata;
    logic       mem_we;
    logic [7:0] alu_I, alu_op1, alu_op2, alu_out;
    logic       alu_cin, alu_cout;
    logic [7:0] acc, out_port;
    logic       flag_c, flag_z, out_valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    nanop_sequencer #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .alu_I(alu_I), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
        .out_port(out_port), .out_valid(out_valid)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // memory and ALU environment
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    function automatic logic [8:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
        case (op)
            8'h01: return {1'b0, a} + {1'b0, b};
            8'h02: return {1'b0, a} - {1'b0, b};
            8'h03: return {1'b0, a} + {1'b0, b} + {8'h00, cin};
            8'h04: return {1'b0, a} - {1'b0, b} - {8'h00, cin};
            8'h05: return {a[7], a[6:0], a[7]};
            8'h06: return {a[0], a[0], a[7:1]};
            8'h07: return {1'b0, a ^ b};
            8'h08: return {1'b0, a & b};
            8'h09: return {1'b0, a | b};
            default: return 9'h000;
        endcase
    endfunction

    assign {alu_cout, alu_out} = alu_fn(alu_I, alu_op1, alu_op2, alu_cin);

    // reference model: phase 0 = opcode fetch, 1 = operand fetch, 2 = execute
    int         m_phase;
    logic [7:0] m_pc, m_i, m_adr, m_acc, m_out;
    logic       m_c, m_z, m_outv;
    logic [8:0] m_res;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_pc = 8'h00; m_i = 8'h00; m_adr = 8'h00;
            m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_out = 8'h00; m_outv = 1'b0;
        end else begin
            m_outv = 1'b0;
            if (m_phase == 0) begin
                if (run) begin
                    m_i = ref_mem[m_pc]; m_pc = m_pc + 8'd1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_adr = ref_mem[m_pc]; m_pc = m_pc + 8'd1; m_phase = 2;
            end else begin
                m_phase = 0;
                m_res = alu_fn(m_i, m_acc, ref_mem[m_adr], m_c);
                if (m_i >= 8'h01 && m_i <= 8'h06) begin
                    m_acc = m_res[7:0]; m_c = m_res[8]; m_z = (m_acc == 8'h00);
                end else if (m_i >= 8'h07 && m_i <= 8'h09) begin
                    m_acc = m_res[7:0]; m_z = (m_acc == 8'h00);
                end else if (m_i == 8'h0A) begin
                    m_acc = ref_mem[m_adr]; m_z = (m_acc == 8'h00);
                end else if (m_i == 8'h0B) begin
                    ref_mem[m_adr] = m_acc;
                end else if (m_i == 8'h0C) begin
                    m_out = m_acc; m_outv = 1'b1;
                end else if (m_i == 8'h0D || (m_i == 8'h0E && !m_c) || (m_i == 8'h0F && !m_z)) begin
                    m_pc = m_adr;
                end
            end
        end
    end

    // scoreboard compare
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    logic [7:0] e_addr;
    always @(negedge clk) begin
        if (chk_on) begin
            e_addr = (m_phase == 2) ? m_adr : m_pc;
            check("mem_addr", mem_addr, e_addr);
            check("mem_we", {7'b0, mem_we}, {7'b0, (m_phase == 2 && m_i == 8'h0B)});
            check("mem_wdata", mem_wdata, m_acc);
            check("alu_I", alu_I, m_i);
            check("alu_op1", alu_op1, m_acc);
            check("alu_op2", alu_op2, ref_mem[e_addr]);
            check("alu_cin", {7'b0, alu_cin}, {7'b0, m_c});
            check("acc", acc, m_acc);
            check("flag_c", {7'b0, flag_c}, {7'b0, m_c});
            check("flag_z", {7'b0, flag_z}, {7'b0, m_z});
            check("out_port", out_port, m_out);
            check("out_valid", {7'b0, out_valid}, {7'b0, m_outv});
        end
    end

    // driver tasks
    task automatic load(input logic [7:0] a, input logic [7:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic enter_reset();
        #2;
        reset_n = 1'b0;
        for (int k = 0; k < 256; k++) load(k[7:0], 8'h00);
    endtask

    // releases reset; returns at the negedge of cycle 1 (the first IF)
    task automatic release_reset();
        run = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) load(k[7:0], 8'h00);
        #1 reset_n = 1'b0;
        chk_on = 1'b1;
        cyc(2);
        check("rst_acc", acc, 8'h00);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_we", {7'b0, mem_we}, 8'h00);
        check("rst_out", out_port, 8'h00);
        check("rst_outv", {7'b0, out_valid}, 8'h00);
        check("rst_flags", {6'b0, flag_c, flag_z}, 8'h00);

        // LDA 10 / ADD 11 / STA 12
        enter_reset();
        load(8'h00, 8'h0A); load(8'h01, 8'h10); load(8'h02, 8'h01); load(8'h03, 8'h11);
        load(8'h04, 8'h0B); load(8'h05, 8'h12); load(8'h10, 8'h05); load(8'h11, 8'h03);
        release_reset();
        cyc(8);
        check("t1_we_c9", {7'b0, mem_we}, 8'h01);
        check("t1_addr_c9", mem_addr, 8'h12);
        check("t1_wdata_c9", mem_wdata, 8'h08);
        cyc(1);
        check("t1_mem12", mem[8'h12], 8'h08);
        check("t1_acc", acc, 8'h08);
        check("t1_flags", {6'b0, flag_c, flag_z}, 8'h00);

        // FF+01 then ADC 00
        enter_reset();
        load(8'h00, 8'h0A); load(8'h01, 8'h40); load(8'h02, 8'h01); load(8'h03, 8'h41);
        load(8'h04, 8'h03); load(8'h05, 8'h42);
        load(8'h40, 8'hFF); load(8'h41, 8'h01); load(8'h42, 8'h00);
        release_reset();
        cyc(6);
        check("t2_add_acc", acc, 8'h00);
        check("t2_add_cz", {6'b0, flag_c, flag_z}, 8'h03);
        cyc(3);
        check("t2_adc_acc", acc, 8'h01);
        check("t2_adc_cz", {6'b0, flag_c, flag_z}, 8'h00);

        // conditional jumps, taken and not taken
        enter_reset();
        load(8'h00, 8'h0A); load(8'h01, 8'h40); load(8'h02, 8'h01); load(8'h03, 8'h41);
        load(8'h04, 8'h0E); load(8'h05, 8'h20); load(8'h06, 8'h0F); load(8'h07, 8'h20);
        load(8'h08, 8'h0A); load(8'h09, 8'h41); load(8'h0A, 8'h0F); load(8'h0B, 8'h30);
        load(8'h30, 8'h01); load(8'h31, 8'h42); load(8'h32, 8'h0E); load(8'h33, 8'h50);
        load(8'h50, 8'h0D); load(8'h51, 8'h60);
        load(8'h40, 8'hFF); load(8'h41, 8'h01); load(8'h42, 8'h00);
        release_reset();
        cyc(9);
        check("t3_jnc_c1", mem_addr, 8'h06);
        cyc(3);
        check("t3_jnz_z1", mem_addr, 8'h08);
        cyc(6);
        check("t3_jnz_z0", mem_addr, 8'h30);
        cyc(6);
        check("t3_jnc_c0", mem_addr, 8'h50);
        cyc(3);
        check("t3_jmp", mem_addr, 8'h60);

        // OUT pulses
        enter_reset();
        load(8'h00, 8'h0A); load(8'h01, 8'h40); load(8'h02, 8'h0C); load(8'h04, 8'h0C);
        load(8'h40, 8'h5A);
        release_reset();
        cyc(6);
        check("t4_outv1", {7'b0, out_valid}, 8'h01);
        check("t4_port", out_port, 8'h5A);
        cyc(1);
        check("t4_outv1_end", {7'b0, out_valid}, 8'h00);
        cyc(2);
        check("t4_outv2", {7'b0, out_valid}, 8'h01);
        cyc(1);
        check("t4_outv2_end", {7'b0, out_valid}, 8'h00);

        // PC wrap at FF, undefined opcode, run=0 freeze
        enter_reset();
        load(8'h00, 8'h30); load(8'h01, 8'h00); load(8'h02, 8'h0D); load(8'h03, 8'hFF);
        load(8'hFF, 8'h0A); load(8'h30, 8'h77);
        release_reset();
        cyc(6);
        check("t5_if_ff", mem_addr, 8'hFF);
        cyc(1);
        check("t5_af_00", mem_addr, 8'h00);
        cyc(1);
        check("t5_adr", mem_addr, 8'h30);
        cyc(1);
        check("t5_next_if", mem_addr, 8'h01);
        check("t5_acc", acc, 8'h77);
        run = 1'b0;
        cyc(5);
        check("t5_frozen_pc", mem_addr, 8'h01);
        check("t5_frozen_acc", acc, 8'h77);
        run = 1'b1;
        cyc(1);
        check("t5_resume", mem_addr, 8'h02);

        // ALU op mix ending in a store
        enter_reset();
        load(8'h00, 8'h0A); load(8'h01, 8'h40); load(8'h02, 8'h05); load(8'h03, 8'h00);
        load(8'h04, 8'h02); load(8'h05, 8'h41); load(8'h06, 8'h04); load(8'h07, 8'h42);
        load(8'h08, 8'h07); load(8'h09, 8'h43); load(8'h0A, 8'h08); load(8'h0B, 8'h44);
        load(8'h0C, 8'h09); load(8'h0D, 8'h45); load(8'h0E, 8'h06); load(8'h0F, 8'h00);
        load(8'h10, 8'h0B); load(8'h11, 8'h46);
        load(8'h40, 8'h81); load(8'h41, 8'h05); load(8'h42, 8'h01); load(8'h43, 8'hFF);
        load(8'h44, 8'h01); load(8'h45, 8'h80);
        release_reset();
        cyc(27);
        check("t7_acc", acc, 8'hC0);
        check("t7_c", {7'b0, flag_c}, 8'h01);
        check("t7_mem46", mem[8'h46], 8'hC0);

        // reset during EX of STA
        enter_reset();
        load(8'h00, 8'h0A); load(8'h01, 8'h40); load(8'h02, 8'h0B); load(8'h03, 8'h50);
        load(8'h40, 8'hAB); load(8'h50, 8'h11);
        release_reset();
        cyc(5);
        check("t6_we_ex", {7'b0, mem_we}, 8'h01);
        check("t6_acc_pre", acc, 8'hAB);
        #2 reset_n = 1'b0;
        #1;
        check("t6_we_drop", {7'b0, mem_we}, 8'h00);
        check("t6_acc_rst", acc, 8'h00);
        check("t6_pc_rst", mem_addr, 8'h00);
        @(posedge clk);
        #1;
        check("t6_no_write", mem[8'h50], 8'h11);
        reset_n = 1'b1;
        cyc(4);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
